// File: rtl/ser_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : ser_deserializer
// Description : Serial-to-parallel receive stage. Samples serIn/serInValid on
//               clkEn pulses and assembles MSB-first words of WIDTH bits.
//               Each completed word is presented on parOut with a one-cycle
//               parValid strobe. Bit/word progress counters are exported, and
//               frames that end early raise a sticky frameErr.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-low reset
//               clkEn      - single-cycle sample enable
//               serIn      - serial data bit
//               serInValid - serial data qualifier
//               parOut     - last completed word (MSB = first bit received)
//               parValid   - one-clk strobe, parOut updated this cycle
//               frameErr   - sticky, last frame ended before WIDTH bits
//               bitCount   - bits received in current frame
//               wordCount  - completed words, modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module ser_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             serIn,
  input  logic             serInValid,
  output logic [WIDTH-1:0] parOut,
  output logic             parValid,
  output logic             frameErr,
  output logic [CNT_W-1:0] bitCount,
  output logic [CNT_W-1:0] wordCount
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state, state_nxt;

  // Only the low WIDTH-1 bits of the shift history are ever needed: the
  // final bit is appended directly when the word is transferred to parOut.
  logic [WIDTH-2:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] par_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] bit_nxt;
  logic [CNT_W-1:0] word_nxt;

  assign shifted = {shreg, serIn};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      parOut    <= '0;
      parValid  <= 1'b0;
      frameErr  <= 1'b0;
      bitCount  <= '0;
      wordCount <= '0;
    end else begin
      shreg     <= shreg_nxt;
      parOut    <= par_nxt;
      parValid  <= valid_nxt;
      frameErr  <= err_nxt;
      bitCount  <= bit_nxt;
      wordCount <= word_nxt;
    end
  end

  // Next-state and datapath decisions; everything holds unless a sample
  // enable arrives, except parValid which always falls back to 0.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    par_nxt   = parOut;
    valid_nxt = 1'b0;
    err_nxt   = frameErr;
    bit_nxt   = bitCount;
    word_nxt  = wordCount;

    if (clkEn) begin
      case (state)
        IDLE: begin
          if (serInValid) begin
            shreg_nxt = shifted[WIDTH-2:0];
            bit_nxt   = CNT_ONE;
            err_nxt   = 1'b0;
            state_nxt = RECV;
          end
        end
        RECV: begin
          if (!serInValid) begin
            // Truncated frame: drop the partial word, keep the last good one.
            err_nxt   = 1'b1;
            bit_nxt   = '0;
            shreg_nxt = '0;
            state_nxt = IDLE;
          end else if (bitCount == LAST_BIT) begin
            par_nxt   = shifted;
            valid_nxt = 1'b1;
            word_nxt  = wordCount + CNT_ONE;
            bit_nxt   = '0;
            shreg_nxt = '0;
            state_nxt = IDLE;
          end else begin
            shreg_nxt = shifted[WIDTH-2:0];
            bit_nxt   = bitCount + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ser_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_deserializer
// Description : Directed self-checking bench for ser_deserializer (WIDTH=8,
//               CNT_W=4) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_deserializer;

  logic       clk;
  logic       rst;
  logic       clkEn;
  logic       serIn;
  logic       serInValid;
  logic [7:0] parOut;
  logic       parValid;
  logic       frameErr;
  logic [3:0] bitCount;
  logic [3:0] wordCount;

  int tests_run = 0;
  int tests_failed = 0;

  ser_deserializer #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .serIn     (serIn),
    .serInValid(serInValid),
    .parOut    (parOut),
    .parValid  (parValid),
    .frameErr  (frameErr),
    .bitCount  (bitCount),
    .wordCount (wordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated enable pulse; returns at the following negedge, by which
  // time the sampling edge has updated the registers.
  task automatic pulse(input logic v, input logic b);
    @(negedge clk);
    clkEn      = 1'b1;
    serInValid = v;
    serIn      = b;
    @(negedge clk);
    clkEn      = 1'b0;
  endtask

  initial begin
    logic [7:0] w_b2;
    logic [7:0] w_81;
    logic [7:0] w_a5;
    logic       saw_valid;

    w_b2 = 8'hB2;
    w_81 = 8'h81;
    w_a5 = 8'hA5;

    rst        = 1'b0;
    clkEn      = 1'b0;
    serIn      = 1'b0;
    serInValid = 1'b0;

    // ---- reset state
    #2;
    check("rst_parOut", 32'(parOut), 32'h00);
    check("rst_parValid", 32'(parValid), 32'h0);
    check("rst_frameErr", 32'(frameErr), 32'h0);
    check("rst_bitCount", 32'(bitCount), 32'h0);
    check("rst_wordCount", 32'(wordCount), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---- single word 8'hB2, bits 1,0,1,1,0,0,1,0
    for (int i = 7; i >= 1; i--) begin
      pulse(1'b1, w_b2[i]);
      check("b2_bitCount", 32'(bitCount), 32'(8 - i));
      check("b2_noValid", 32'(parValid), 32'h0);
    end
    pulse(1'b1, w_b2[0]);
    check("b2_parOut", 32'(parOut), 32'hB2);
    check("b2_parValid", 32'(parValid), 32'h1);
    check("b2_wordCount", 32'(wordCount), 32'h1);
    check("b2_bitCount_end", 32'(bitCount), 32'h0);
    @(negedge clk);
    check("b2_parValid_drop", 32'(parValid), 32'h0);

    // ---- partial frame of 3 bits, then enable gating for 50 clks
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    check("part_bitCount", 32'(bitCount), 32'h3);
    saw_valid  = 1'b0;
    serInValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      serIn = ~serIn;
      if (parValid) saw_valid = 1'b1;
    end
    check("gate_noValid", 32'(saw_valid), 32'h0);
    check("gate_bitCount", 32'(bitCount), 32'h3);
    check("gate_parOut", 32'(parOut), 32'hB2);
    check("gate_wordCount", 32'(wordCount), 32'h1);

    // ---- truncated frame
    pulse(1'b0, 1'b1);
    check("trunc_frameErr", 32'(frameErr), 32'h1);
    check("trunc_bitCount", 32'(bitCount), 32'h0);
    check("trunc_parOut", 32'(parOut), 32'hB2);
    check("trunc_noValid", 32'(parValid), 32'h0);
    check("trunc_wordCount", 32'(wordCount), 32'h1);
    pulse(1'b1, w_81[7]);
    check("restart_frameErr", 32'(frameErr), 32'h0);
    check("restart_bitCount", 32'(bitCount), 32'h1);
    for (int i = 6; i >= 0; i--) pulse(1'b1, w_81[i]);
    check("w81_parOut", 32'(parOut), 32'h81);
    check("w81_parValid", 32'(parValid), 32'h1);
    check("w81_wordCount", 32'(wordCount), 32'h2);

    // ---- idle invalid pulses
    for (int i = 0; i < 10; i++) begin
      pulse(1'b0, 1'b1);
      check("idle_bitCount", 32'(bitCount), 32'h0);
      check("idle_parValid", 32'(parValid), 32'h0);
    end
    check("idle_frameErr", 32'(frameErr), 32'h0);
    check("idle_parOut", 32'(parOut), 32'h81);
    check("idle_wordCount", 32'(wordCount), 32'h2);

    // ---- asynchronous reset mid-frame at bitCount=5
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b1);
    check("pre_rst_bitCount", 32'(bitCount), 32'h5);
    #2;
    rst = 1'b0;
    #1;
    check("arst_parOut", 32'(parOut), 32'h00);
    check("arst_bitCount", 32'(bitCount), 32'h0);
    check("arst_wordCount", 32'(wordCount), 32'h0);
    check("arst_frameErr", 32'(frameErr), 32'h0);
    check("arst_parValid", 32'(parValid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_bitCount", 32'(bitCount), 32'h0);
    check("post_rst_parValid", 32'(parValid), 32'h0);

    // ---- 17 back-to-back words of 8'hA5 with clkEn held high
    for (int w = 1; w <= 17; w++) begin
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk);
        if (i == 7 && w > 1) begin
          check("b2b_parValid", 32'(parValid), 32'h1);
          check("b2b_parOut", 32'(parOut), 32'hA5);
          check("b2b_wordCount", 32'(wordCount), 32'((w - 1) % 16));
          check("b2b_bitCount", 32'(bitCount), 32'h0);
        end else if (w > 1 || i < 7) begin
          check("b2b_noValid", 32'(parValid), 32'h0);
        end
        clkEn      = 1'b1;
        serInValid = 1'b1;
        serIn      = w_a5[i];
      end
    end
    @(negedge clk);
    clkEn      = 1'b0;
    serInValid = 1'b0;
    check("b2b_last_parValid", 32'(parValid), 32'h1);
    check("b2b_last_parOut", 32'(parOut), 32'hA5);
    check("b2b_last_wordCount", 32'(wordCount), 32'h1);
    @(negedge clk);
    check("b2b_last_drop", 32'(parValid), 32'h0);
    check("b2b_frameErr", 32'(frameErr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ser_deserializer.md
Name: ser_deserializer

Overview:
Serial-to-parallel receive stage that sits directly downstream of the serial transmitter. It samples the transmitter's serOut/serOutValid pair on single-cycle clock-enable pulses from the one-pulser and assembles MSB-first words. It emits each completed word with a one-cycle valid strobe. It also exports bit and word counters so the seven-segment driver can display progress, and it flags frames that are cut short.

Parameters:
WIDTH, 8, bits per word; legal range 2..15
CNT_W, 4, width of bitCount and wordCount outputs; must hold WIDTH-1

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low; clears all state while 0
clkEn  input  1  one-cycle sample enable from one-pulser; sampling only on cycles with clkEn=1
serIn  input  1  serial data bit (transmitter serOut)
serInValid  input  1  serial data qualifier (transmitter serOutValid)
parOut  output  WIDTH  last completed word, MSB = first bit received
parValid  output  1  one-clk strobe: parOut updated this cycle
frameErr  output  1  sticky: last frame ended before WIDTH bits
bitCount  output  CNT_W  bits received in current frame, 0..WIDTH-1
wordCount  output  CNT_W  completed words, modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; shreg=0; parOut=0; parValid=0; frameErr=0; bitCount=0; wordCount=0. Takes effect immediately regardless of clk. Reset mid-frame discards the partial word; no parValid.
- Cycles with clkEn=0: all registers hold, except parValid, which returns to 0.
- parValid defaults to 0 every cycle. It is only ever high for exactly one clk.
- States: IDLE, RECV.
- IDLE, clkEn=1, serInValid=1:
  - shreg <= {shreg[WIDTH-2:0], serIn}; bitCount <= 1; frameErr <= 0; go to RECV.
- IDLE, clkEn=1, serInValid=0: no change.
- RECV, clkEn=1, serInValid=1, bitCount < WIDTH-1:
  - shift in serIn; bitCount <= bitCount+1.
- RECV, clkEn=1, serInValid=1, bitCount == WIDTH-1 (final bit):
  - parOut <= {shreg[WIDTH-2:0], serIn}; parValid <= 1; wordCount <= wordCount+1 (wraps 2^CNT_W-1 -> 0); bitCount <= 0; shreg <= 0; go to IDLE.
- RECV, clkEn=1, serInValid=0 (truncated frame):
  - frameErr <= 1; bitCount <= 0; shreg <= 0; go to IDLE.
  - parOut, parValid and wordCount are unchanged.
- Latency: parOut and parValid are registered and visible the clk after the sampling edge of the final bit.
- Back-to-back words: the enable pulse after the final bit, with serInValid=1, starts a new frame from IDLE. No gap is required.
- frameErr clears only on the start of the next frame (first sampled valid bit) or on reset. It is not cleared by parValid.
- serIn is ignored whenever serInValid=0.
- Synchronous, single clock domain. clkEn is already synchronous (one-pulser output). No internal synchronizers.

Test Plan:
- Reset: drive rst=0 mid-operation with bitCount=5 -> all outputs 0 immediately (asynchronously); after release, IDLE and no parValid.
- Single word: WIDTH=8, 8 enable pulses with serInValid=1 and bits 1,0,1,1,0,0,1,0 -> one clk after the 8th pulse, parOut=8'hB2 and parValid=1 for one clk; wordCount=1; bitCount sequence 1..7 then 0.
- Enable gating: hold serInValid=1 and toggle serIn for 50 clks with clkEn=0 -> bitCount, parOut and wordCount unchanged, parValid never asserts.
- Truncated frame: 3 valid bits, then a pulse with serInValid=0 -> frameErr=1, bitCount=0, parOut retains its previous value, no parValid; next valid pulse -> frameErr=0, bitCount=1.
- Back-to-back and wrap: 17 consecutive words of 8'hA5 with no gap -> 17 parValid strobes each with parOut=8'hA5; wordCount reads 15 after word 15, 0 after word 16, 1 after word 17.
- Idle invalid pulses: 10 pulses with serInValid=0 in IDLE -> no state change, frameErr remains 0.
